// File: rtl/acc_dispatch.sv
// acc_dispatch: queues accelerator jobs from the core and hands them to
// NUM_CH accelerator channels in round-robin order. Each channel has a small
// IDLE/BUSY FSM whose state is visible on ch_busy.
// Optional watchdog: define ACC_TIMEOUT_EN to return a channel to IDLE after
// TIMEOUT busy cycles without ch_done, and to set the sticky err flag.
//
// Handshake: a request is taken at a rising edge when req_valid & req_ready;
// req_ready depends only on the registered FIFO count, so a full FIFO refuses
// a request even if a dispatch frees a slot in the same cycle.
module acc_dispatch #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 6,
  parameter int SIZE_W  = 6,
  parameter int QDEPTH  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [SIZE_W-1:0]          req_size,
  output logic                       req_ready,
  input  logic [NUM_CH-1:0]          ch_done,
  output logic [NUM_CH-1:0]          ch_start,
  output logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  output logic [NUM_CH*SIZE_W-1:0]   ch_size,
  output logic [NUM_CH-1:0]          ch_busy,
  output logic [$clog2(QDEPTH):0]    q_count,
  output logic [7:0]                 done_cnt,
  output logic                       all_idle,
  output logic                       err
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam int RW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("acc_dispatch: TIMEOUT must be in 1..255");
  end

  typedef enum logic {CH_IDLE = 1'b0, CH_BUSY = 1'b1} ch_state_t;

  ch_state_t ch_state     [NUM_CH];
  ch_state_t ch_state_nxt [NUM_CH];

  logic [ADDR_W-1:0] q_addr [QDEPTH];
  logic [SIZE_W-1:0] q_size [QDEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [RW-1:0]     rr_ptr, sel;
  logic              found, disp, accept, enq, zero_acc;
  logic [3:0]        inc;
  logic [NUM_CH-1:0] wd_hit;

  assign req_ready = (q_count != FULL);
  assign accept    = req_valid & req_ready;
  assign enq       = accept & (req_size != '0);
  assign zero_acc  = accept & (req_size == '0);
  assign all_idle  = (q_count == '0) & ~|ch_busy;
  assign disp      = (q_count != '0) & found;

  // Pick the first idle channel at or after rr_ptr, wrapping modulo NUM_CH.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && !ch_busy[(int'(rr_ptr) + i) % NUM_CH]) begin
        found = 1'b1;
        sel   = RW'((int'(rr_ptr) + i) % NUM_CH);
      end
    end
  end

  // Completions this cycle: busy channels reporting done, plus a zero-size accept.
  always_comb begin
    inc = {3'b000, zero_acc};
    for (int c = 0; c < NUM_CH; c++) begin
      inc = inc + {3'b000, ch_done[c] & ch_busy[c]};
    end
  end

  // FIFO storage; contents are only meaningful between wr_ptr and rd_ptr.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_addr[wr_ptr] <= req_addr;
      q_size[wr_ptr] <= req_size;
    end
  end

  // FIFO pointers, occupancy, round-robin pointer and completion counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      q_count  <= '0;
      rr_ptr   <= '0;
      done_cnt <= '0;
    end else begin
      if (enq)  wr_ptr <= wr_ptr + 1'b1;
      if (disp) begin
        rd_ptr <= rd_ptr + 1'b1;
        rr_ptr <= RW'((int'(sel) + 1) % NUM_CH);
      end
      q_count  <= q_count + CW'(enq) - CW'(disp);
      done_cnt <= done_cnt + {4'b0000, inc};
    end
  end

  // Dispatch datapath: one-cycle start pulse, address/size held until next dispatch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch_start <= '0;
      ch_addr  <= '0;
      ch_size  <= '0;
    end else begin
      ch_start <= '0;
      if (disp) begin
        ch_start[sel]                          <= 1'b1;
        ch_addr[int'(sel)*ADDR_W +: ADDR_W]    <= q_addr[rd_ptr];
        ch_size[int'(sel)*SIZE_W +: SIZE_W]    <= q_size[rd_ptr];
      end
    end
  end

  // Channel FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) ch_state[c] <= CH_IDLE;
    end else begin
      for (int c = 0; c < NUM_CH; c++) ch_state[c] <= ch_state_nxt[c];
    end
  end

  // Channel FSM next state: dispatch starts a job, done or watchdog ends it.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ch_state_nxt[c] = ch_state[c];
      case (ch_state[c])
        CH_IDLE: if (disp && int'(sel) == c) ch_state_nxt[c] = CH_BUSY;
        CH_BUSY: if (ch_done[c] || wd_hit[c]) ch_state_nxt[c] = CH_IDLE;
        default: ch_state_nxt[c] = CH_IDLE;
      endcase
    end
  end

  // Channel FSM outputs.
  always_comb begin
    ch_busy = '0;
    for (int c = 0; c < NUM_CH; c++) ch_busy[c] = (ch_state[c] == CH_BUSY);
  end

`ifdef ACC_TIMEOUT_EN
  logic [7:0] wd_cnt [NUM_CH];

  // Watchdog fires on the edge where the count would reach TIMEOUT.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      wd_hit[c] = ch_busy[c] & ~ch_done[c] & (wd_cnt[c] == 8'(TIMEOUT - 1));
    end
  end

  // Busy-cycle counters (cleared on dispatch) and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) wd_cnt[c] <= '0;
      err <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (disp && int'(sel) == c) wd_cnt[c] <= '0;
        else if (ch_busy[c])        wd_cnt[c] <= wd_cnt[c] + 8'd1;
      end
      if (|wd_hit) err <= 1'b1;
    end
  end
`else
  assign wd_hit = '0;
  assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_acc_dispatch.sv
// Directed bench for acc_dispatch (NUM_CH=2, ADDR_W=6, SIZE_W=6, QDEPTH=4),
// default build without the watchdog.
module tb_acc_dispatch;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [5:0]  req_addr;
  logic [5:0]  req_size;
  logic        req_ready;
  logic [1:0]  ch_done;
  logic [1:0]  ch_start;
  logic [11:0] ch_addr;
  logic [11:0] ch_size;
  logic [1:0]  ch_busy;
  logic [2:0]  q_count;
  logic [7:0]  done_cnt;
  logic        all_idle;
  logic        err;

  int n_cmp  = 0;
  int n_fail = 0;

  acc_dispatch #(
    .NUM_CH(2), .ADDR_W(6), .SIZE_W(6), .QDEPTH(4), .TIMEOUT(255)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_size(req_size),
    .req_ready(req_ready), .ch_done(ch_done), .ch_start(ch_start),
    .ch_addr(ch_addr), .ch_size(ch_size), .ch_busy(ch_busy),
    .q_count(q_count), .done_cnt(done_cnt), .all_idle(all_idle), .err(err)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [5:0]  a;
    logic [5:0]  s;
    logic [1:0]  d;
    logic [1:0]  start;
    logic [1:0]  busy;
    logic [2:0]  q;
    logic [7:0]  dc;
    logic        rdy;
    logic        idle;
    logic [11:0] addr;
    logic [11:0] size;
  } vec_t;

  localparam int NV = 27;
  vec_t vt [NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got %0h expected %0h", name, row, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] a, input logic [5:0] s,
                       input logic [1:0] d);
    req_valid = v;
    req_addr  = a;
    req_size  = s;
    ch_done   = d;
  endtask

  task automatic chk_reset_vals(input int row);
    chk("rst_start", row, 32'(ch_start), 32'h0);
    chk("rst_busy",  row, 32'(ch_busy),  32'h0);
    chk("rst_q",     row, 32'(q_count),  32'h0);
    chk("rst_dc",    row, 32'(done_cnt), 32'h0);
    chk("rst_addr",  row, 32'(ch_addr),  32'h0);
    chk("rst_size",  row, 32'(ch_size),  32'h0);
    chk("rst_ready", row, 32'(req_ready), 32'h1);
    chk("rst_idle",  row, 32'(all_idle), 32'h1);
    chk("rst_err",   row, 32'(err),      32'h0);
  endtask

  initial begin
    //        v  a   s  d      start  busy   q  dc  rdy idle addr     size
    vt[0]  = '{1, 5,  8, 2'b00, 2'b00, 2'b00, 1, 0,  1, 0, 12'h000, 12'h000};
    vt[1]  = '{0, 0,  0, 2'b00, 2'b01, 2'b01, 0, 0,  1, 0, 12'h005, 12'h008};
    vt[2]  = '{0, 0,  0, 2'b01, 2'b00, 2'b00, 0, 1,  1, 1, 12'h005, 12'h008};
    vt[3]  = '{1, 10, 3, 2'b00, 2'b00, 2'b00, 1, 1,  1, 0, 12'h005, 12'h008};
    vt[4]  = '{1, 11, 4, 2'b00, 2'b10, 2'b10, 1, 1,  1, 0, 12'h285, 12'h0C8};
    vt[5]  = '{1, 12, 5, 2'b00, 2'b01, 2'b11, 1, 1,  1, 0, 12'h28B, 12'h0C4};
    vt[6]  = '{0, 0,  0, 2'b00, 2'b00, 2'b11, 1, 1,  1, 0, 12'h28B, 12'h0C4};
    vt[7]  = '{0, 0,  0, 2'b10, 2'b00, 2'b01, 1, 2,  1, 0, 12'h28B, 12'h0C4};
    vt[8]  = '{0, 0,  0, 2'b00, 2'b10, 2'b11, 0, 2,  1, 0, 12'h30B, 12'h144};
    vt[9]  = '{1, 20, 1, 2'b00, 2'b00, 2'b11, 1, 2,  1, 0, 12'h30B, 12'h144};
    vt[10] = '{1, 21, 1, 2'b00, 2'b00, 2'b11, 2, 2,  1, 0, 12'h30B, 12'h144};
    vt[11] = '{1, 22, 1, 2'b00, 2'b00, 2'b11, 3, 2,  1, 0, 12'h30B, 12'h144};
    vt[12] = '{1, 23, 1, 2'b00, 2'b00, 2'b11, 4, 2,  0, 0, 12'h30B, 12'h144};
    vt[13] = '{1, 24, 1, 2'b00, 2'b00, 2'b11, 4, 2,  0, 0, 12'h30B, 12'h144};
    vt[14] = '{1, 24, 1, 2'b01, 2'b00, 2'b10, 4, 3,  0, 0, 12'h30B, 12'h144};
    vt[15] = '{1, 24, 1, 2'b00, 2'b01, 2'b11, 3, 3,  1, 0, 12'h314, 12'h141};
    vt[16] = '{1, 24, 1, 2'b00, 2'b00, 2'b11, 4, 3,  0, 0, 12'h314, 12'h141};
    vt[17] = '{0, 0,  0, 2'b11, 2'b00, 2'b00, 4, 5,  0, 0, 12'h314, 12'h141};
    vt[18] = '{0, 0,  0, 2'b00, 2'b10, 2'b10, 3, 5,  1, 0, 12'h554, 12'h041};
    vt[19] = '{0, 0,  0, 2'b00, 2'b01, 2'b11, 2, 5,  1, 0, 12'h556, 12'h041};
    vt[20] = '{1, 30, 0, 2'b00, 2'b00, 2'b11, 2, 6,  1, 0, 12'h556, 12'h041};
    vt[21] = '{0, 0,  0, 2'b10, 2'b00, 2'b01, 2, 7,  1, 0, 12'h556, 12'h041};
    vt[22] = '{0, 0,  0, 2'b00, 2'b10, 2'b11, 1, 7,  1, 0, 12'h5D6, 12'h041};
    vt[23] = '{0, 0,  0, 2'b11, 2'b00, 2'b00, 1, 9,  1, 0, 12'h5D6, 12'h041};
    vt[24] = '{0, 0,  0, 2'b00, 2'b01, 2'b01, 0, 9,  1, 0, 12'h5D8, 12'h041};
    vt[25] = '{0, 0,  0, 2'b10, 2'b00, 2'b01, 0, 9,  1, 0, 12'h5D8, 12'h041};
    vt[26] = '{0, 0,  0, 2'b01, 2'b00, 2'b00, 0, 10, 1, 1, 12'h5D8, 12'h041};

    // Reset
    reset = 1'b0;
    drive(1'b0, 6'd0, 6'd0, 2'b00);
    repeat (3) step();
    chk_reset_vals(-1);
    reset = 1'b1;

    // Table-driven sequence
    for (int i = 0; i < NV; i++) begin
      drive(vt[i].v, vt[i].a, vt[i].s, vt[i].d);
      step();
      chk("ch_start",  i, 32'(ch_start),  32'(vt[i].start));
      chk("ch_busy",   i, 32'(ch_busy),   32'(vt[i].busy));
      chk("q_count",   i, 32'(q_count),   32'(vt[i].q));
      chk("done_cnt",  i, 32'(done_cnt),  32'(vt[i].dc));
      chk("req_ready", i, 32'(req_ready), 32'(vt[i].rdy));
      chk("all_idle",  i, 32'(all_idle),  32'(vt[i].idle));
      chk("ch_addr",   i, 32'(ch_addr),   32'(vt[i].addr));
      chk("ch_size",   i, 32'(ch_size),   32'(vt[i].size));
      chk("err",       i, 32'(err),       32'h0);
    end

    // Async reset in the middle of a job, between clock edges
    drive(1'b1, 6'd7, 6'd9, 2'b00);
    step();
    drive(1'b0, 6'd0, 6'd0, 2'b00);
    step();
    chk("mid_busy", 100, 32'(ch_busy),  32'h2);
    chk("mid_addr", 100, 32'(ch_addr),  32'h1D8);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals(101);
    step();
    reset = 1'b1;
    drive(1'b0, 6'd0, 6'd0, 2'b10);
    step();
    chk("late_done_dc",   102, 32'(done_cnt), 32'h0);
    chk("late_done_busy", 102, 32'(ch_busy),  32'h0);

    // After reset rr_ptr is 0: first job goes to ch0
    drive(1'b1, 6'd3, 6'd2, 2'b00);
    step();
    drive(1'b0, 6'd0, 6'd0, 2'b00);
    step();
    chk("rr0_start", 103, 32'(ch_start), 32'h1);
    chk("rr0_addr",  103, 32'(ch_addr),  32'h003);
    // Zero-size accept and a channel done in the same cycle
    drive(1'b1, 6'd1, 6'd0, 2'b01);
    step();
    chk("both_inc_dc", 104, 32'(done_cnt), 32'h2);
    chk("both_inc_q",  104, 32'(q_count),  32'h0);
    chk("both_inc_st", 104, 32'(ch_start), 32'h0);
    // Counter wrap 255 -> 0
    drive(1'b1, 6'd1, 6'd0, 2'b00);
    for (int i = 0; i < 253; i++) step();
    chk("dc_255", 105, 32'(done_cnt), 32'hFF);
    step();
    chk("dc_wrap", 106, 32'(done_cnt), 32'h0);
    chk("wrap_idle", 106, 32'(all_idle), 32'h1);
    drive(1'b0, 6'd0, 6'd0, 2'b00);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
